frame_deframer: RTL and testbench
=================================

Name: frame_deframer

Overview:
- Receive-side stage directly downstream of the framer. Consumes the framer's byte stream (frame_valid/frame_data) and locates frames by sync word.
- Validates the header and CRC, forwards payload bytes, and reports per-frame status and TXFN sequence continuity.
- Used in loopback benches and on the relay receive path ahead of payload sinks.

Parameters:
- DATA_WIDTH, 8, stream byte width (only 8 supported)
- MAX_PAYLOAD, 4096, largest legal payload length in bytes
- SYNC_WORD, 16'h1ACF, frame sync marker, transmitted high byte first

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input byte strobe (framer frame_valid)
- in_data  in  DATA_WIDTH  input byte (framer frame_data)
- out_valid  out  1  payload byte valid
- out_data  out  DATA_WIDTH  payload byte
- out_sof  out  1  marks first payload byte
- out_eof  out  1  marks last payload byte
- hdr_valid  out  1  one-cycle pulse; header fields valid
- hdr_type  out  2  frame type
- hdr_txfn  out  16  transmit frame number
- hdr_len  out  16  payload length
- frame_ok  out  1  one-cycle pulse; CRC good
- frame_err  out  1  one-cycle pulse; frame rejected
- err_code  out  2  1=bad type, 2=bad length, 3=CRC mismatch; held until next frame_ok/frame_err
- seq_gap  out  1  valid with frame_ok; TXFN not equal to previous good TXFN+1
- frame_count  out  16  count of good frames; wraps at 0xFFFF

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs go to 0. State goes to HUNT. CRC register goes to 0xFFFF. The have_prev flag is cleared.
  - Reset mid-frame discards the partial frame and raises no pulse.
- Frame format, byte order on the wire:
  - SYNC_HI, SYNC_LO, TYPE, TXFN_HI, TXFN_LO, LEN_HI, LEN_LO
  - then LEN payload bytes
  - then CRC_HI, CRC_LO
- CRC: CRC-16/CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR.
  - Computed over TYPE through the last payload byte.
  - Sync and CRC bytes are excluded.
- Input handling:
  - Bytes are consumed only when in_valid=1. Gaps of any length are allowed.
  - There is no backpressure; the block must accept one byte every cycle.
- States:
  - HUNT: in_data==SYNC_WORD[15:8] moves to SYNC2.
  - SYNC2:
    - SYNC_WORD[7:0] moves to HDR and reloads the CRC to 0xFFFF.
    - SYNC_WORD[15:8] stays in SYNC2.
    - Any other byte returns to HUNT.
  - HDR: 5 bytes, counted by a 3-bit index. On LEN_LO:
    - If TYPE[7:2]!=0: frame_err, err_code=1, go to HUNT.
    - Else if LEN==0 or LEN>MAX_PAYLOAD: frame_err, err_code=2, go to HUNT.
    - Else: hdr_valid pulses the next cycle with the fields registered, and the state moves to PAYLOAD.
  - PAYLOAD: forward LEN bytes using a 16-bit down-counter, then go to CRC.
  - CRC: 2 bytes. After CRC_LO, compare against the computed value:
    - Match: frame_ok.
    - Mismatch: frame_err with err_code=3.
    - In both cases return to HUNT.
- Latency:
  - out_valid/out_data are registered, 1 cycle after the input byte.
  - out_sof accompanies payload byte 0. out_eof accompanies byte LEN-1. Both are set together when LEN=1.
  - frame_ok/frame_err pulse 1 cycle after CRC_LO is accepted.
- Payload integrity: payload is forwarded before the CRC is known. Sinks must discard it on frame_err.
- Sequence check, evaluated on frame_ok only:
  - seq_gap=1 iff have_prev && txfn != prev_txfn+1 (16-bit, 0xFFFF+1=0x0000).
  - After the check: prev_txfn=txfn, have_prev=1, frame_count increments.
  - Errored frames do not update prev_txfn.
- Back-to-back frames: SYNC_HI of the next frame may arrive the cycle after CRC_LO.
  - It must be recognised; zero idle cycles are required between frames.
  - frame_ok of frame N and sync detection of frame N+1 may occur in the same cycle.
- No resync inside a frame: once in HDR, PAYLOAD or CRC, sync-valued bytes are treated as data.

Test Plan:
- Frame type=1, txfn=0x1234, len=20, payload 20×0xAA, correct CRC, gapless: hdr_valid with (1, 0x1234, 20); 20 out_valid bytes of 0xAA with sof on the first and eof on the last; frame_ok; seq_gap=0; frame_count=1.
- Back-to-back: txfn 0x1234 then 0x1235 with zero idle cycles, then 0x1237: both first frames give frame_ok with seq_gap=0; the third gives frame_ok with seq_gap=1; frame_count=3.
- Wrap: txfn 0xFFFF then 0x0000: seq_gap=0 on the second frame.
- CRC corruption (flip bit 0 of CRC_LO): frame_err, err_code=3; frame_count unchanged; the next good frame with txfn=prev_good+1 has seq_gap=0.
- Header errors: TYPE=0x05 gives err_code=1; LEN=0 gives err_code=2; LEN=4097 gives err_code=2. Each returns to HUNT with no out_valid, and the following valid frame is received correctly.
- Robustness:
  - Input 0x00, 0x1A, 0x1A, 0xCF, then a valid frame, with random in_valid gaps (about 30% idle): the frame is received OK.
  - Asserting rst_n=0 mid-payload gives all outputs 0 and no pulses.
  - The next frame after reset reports seq_gap=0 regardless of its txfn.

Source files
------------

// File: rtl/frame_deframer.sv
// Receive-side deframer: hunts for the sync word, validates header and CRC-16/CCITT,
// forwards payload bytes and reports per-frame status plus TXFN sequence continuity.
module frame_deframer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned MAX_PAYLOAD = 4096,
  parameter logic [15:0] SYNC_WORD   = 16'h1ACF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_sof_o,
  output logic                  out_eof_o,
  output logic                  hdr_valid_o,
  output logic [1:0]            hdr_type_o,
  output logic [15:0]           hdr_txfn_o,
  output logic [15:0]           hdr_len_o,
  output logic                  frame_ok_o,
  output logic                  frame_err_o,
  output logic [1:0]            err_code_o,
  output logic                  seq_gap_o,
  output logic [15:0]           frame_count_o
);

  localparam logic [16:0] MaxLen = 17'(MAX_PAYLOAD);

  typedef enum logic [2:0] {StHunt, StSync2, StHdr, StPayload, StCrc} state_e;

  // One byte of CRC-16/CCITT (poly 0x1021), MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  state_e                state_q, state_d;
  logic [15:0]           crc_q, crc_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            type_q, type_d;
  logic [15:0]           txfn_q, txfn_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [7:0]            crc_hi_q, crc_hi_d;
  logic [15:0]           prev_txfn_q, prev_txfn_d;
  logic                  have_prev_q, have_prev_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sof_q, out_sof_d;
  logic                  out_eof_q, out_eof_d;
  logic                  hdr_valid_q, hdr_valid_d;
  logic [1:0]            hdr_type_q, hdr_type_d;
  logic [15:0]           hdr_txfn_q, hdr_txfn_d;
  logic [15:0]           hdr_len_q, hdr_len_d;
  logic                  frame_ok_q, frame_ok_d;
  logic                  frame_err_q, frame_err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  seq_gap_q, seq_gap_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic [15:0]           len_full;
  logic [15:0]           rx_crc;

  assign len_full = {len_hi_q, in_data_i};
  assign rx_crc   = {crc_hi_q, in_data_i};

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    idx_d         = idx_q;
    type_d        = type_q;
    txfn_d        = txfn_q;
    len_hi_d      = len_hi_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    crc_hi_d      = crc_hi_q;
    prev_txfn_d   = prev_txfn_q;
    have_prev_d   = have_prev_q;
    out_valid_d   = 1'b0;
    out_data_d    = out_data_q;
    out_sof_d     = 1'b0;
    out_eof_d     = 1'b0;
    hdr_valid_d   = 1'b0;
    hdr_type_d    = hdr_type_q;
    hdr_txfn_d    = hdr_txfn_q;
    hdr_len_d     = hdr_len_q;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    seq_gap_d     = 1'b0;
    frame_count_d = frame_count_q;

    if (in_valid_i) begin
      unique case (state_q)
        StHunt: begin
          if (in_data_i == SYNC_WORD[15:8]) state_d = StSync2;
        end
        StSync2: begin
          if (in_data_i == SYNC_WORD[7:0]) begin
            state_d = StHdr;
            crc_d   = 16'hFFFF;
            idx_d   = 3'd0;
          end else if (in_data_i != SYNC_WORD[15:8]) begin
            state_d = StHunt;
          end
        end
        StHdr: begin
          crc_d = crc_step(crc_q, in_data_i);
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd0:    type_d         = in_data_i;
            3'd1:    txfn_d[15:8]   = in_data_i;
            3'd2:    txfn_d[7:0]    = in_data_i;
            3'd3:    len_hi_d       = in_data_i;
            default: begin
              state_d = StHunt;
              if (type_q[7:2] != 6'd0) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd1;
              end else if (len_full == 16'd0 || {1'b0, len_full} > MaxLen) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd2;
              end else begin
                hdr_valid_d = 1'b1;
                hdr_type_d  = type_q[1:0];
                hdr_txfn_d  = txfn_q;
                hdr_len_d   = len_full;
                len_d       = len_full;
                cnt_d       = len_full;
                state_d     = StPayload;
              end
            end
          endcase
        end
        StPayload: begin
          crc_d       = crc_step(crc_q, in_data_i);
          out_valid_d = 1'b1;
          out_data_d  = in_data_i;
          out_sof_d   = (cnt_q == len_q);
          out_eof_d   = (cnt_q == 16'd1);
          cnt_d       = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = StCrc;
            idx_d   = 3'd0;
          end
        end
        StCrc: begin
          if (idx_q == 3'd0) begin
            crc_hi_d = in_data_i;
            idx_d    = 3'd1;
          end else begin
            state_d = StHunt;
            if (rx_crc == crc_q) begin
              frame_ok_d    = 1'b1;
              err_code_d    = 2'd0;
              seq_gap_d     = have_prev_q && (txfn_q != prev_txfn_q + 16'd1);
              prev_txfn_d   = txfn_q;
              have_prev_d   = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end else begin
              frame_err_d = 1'b1;
              err_code_d  = 2'd3;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StHunt;
      crc_q         <= 16'hFFFF;
      idx_q         <= 3'd0;
      type_q        <= 8'd0;
      txfn_q        <= 16'd0;
      len_hi_q      <= 8'd0;
      len_q         <= 16'd0;
      cnt_q         <= 16'd0;
      crc_hi_q      <= 8'd0;
      prev_txfn_q   <= 16'd0;
      have_prev_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sof_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      hdr_valid_q   <= 1'b0;
      hdr_type_q    <= 2'd0;
      hdr_txfn_q    <= 16'd0;
      hdr_len_q     <= 16'd0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'd0;
      seq_gap_q     <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      crc_q         <= crc_d;
      idx_q         <= idx_d;
      type_q        <= type_d;
      txfn_q        <= txfn_d;
      len_hi_q      <= len_hi_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      crc_hi_q      <= crc_hi_d;
      prev_txfn_q   <= prev_txfn_d;
      have_prev_q   <= have_prev_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sof_q     <= out_sof_d;
      out_eof_q     <= out_eof_d;
      hdr_valid_q   <= hdr_valid_d;
      hdr_type_q    <= hdr_type_d;
      hdr_txfn_q    <= hdr_txfn_d;
      hdr_len_q     <= hdr_len_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      seq_gap_q     <= seq_gap_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_sof_o     = out_sof_q;
  assign out_eof_o     = out_eof_q;
  assign hdr_valid_o   = hdr_valid_q;
  assign hdr_type_o    = hdr_type_q;
  assign hdr_txfn_o    = hdr_txfn_q;
  assign hdr_len_o     = hdr_len_q;
  assign frame_ok_o    = frame_ok_q;
  assign frame_err_o   = frame_err_q;
  assign err_code_o    = err_code_q;
  assign seq_gap_o     = seq_gap_q;
  assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_frame_deframer.sv
// Scoreboard bench for frame_deframer: expectations are queued as bytes are driven and
// popped by a monitor when the deframer reports payload, header or frame status.
module tb_frame_deframer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [7:0]  in_data_i = 8'h00;
  logic        out_valid_o, out_sof_o, out_eof_o, hdr_valid_o;
  logic [7:0]  out_data_o;
  logic [1:0]  hdr_type_o, err_code_o;
  logic [15:0] hdr_txfn_o, hdr_len_o, frame_count_o;
  logic        frame_ok_o, frame_err_o, seq_gap_o;

  always #5 clk_i = ~clk_i;

  frame_deframer #(
    .DATA_WIDTH (8),
    .MAX_PAYLOAD(4096),
    .SYNC_WORD  (16'h1ACF)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_sof_o    (out_sof_o),
    .out_eof_o    (out_eof_o),
    .hdr_valid_o  (hdr_valid_o),
    .hdr_type_o   (hdr_type_o),
    .hdr_txfn_o   (hdr_txfn_o),
    .hdr_len_o    (hdr_len_o),
    .frame_ok_o   (frame_ok_o),
    .frame_err_o  (frame_err_o),
    .err_code_o   (err_code_o),
    .seq_gap_o    (seq_gap_o),
    .frame_count_o(frame_count_o)
  );

  typedef struct {
    bit          ok;
    logic [1:0]  code;
    bit          gap;
    logic [15:0] cnt;
  } status_t;

  int checks = 0;
  int failures = 0;

  logic [9:0]  pay_q[$];  // {sof, eof, data}
  logic [33:0] hdr_q[$];  // {type, txfn, len}
  status_t     st_q[$];

  bit          have_prev = 1'b0;
  logic [15:0] prev_txfn = 16'h0;
  logic [15:0] good_cnt = 16'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference CRC-16/CCITT.
  function automatic logic [15:0] crc_bits(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  always @(negedge clk_i) begin
    logic [9:0]  pe;
    logic [33:0] he;
    status_t     se;
    if (out_valid_o) begin
      if (pay_q.size() == 0) check("pay_unexpected", 1, 0);
      else begin
        pe = pay_q.pop_front();
        check("pay_data", {24'h0, out_data_o}, {24'h0, pe[7:0]});
        check("pay_sof", {31'h0, out_sof_o}, {31'h0, pe[9]});
        check("pay_eof", {31'h0, out_eof_o}, {31'h0, pe[8]});
      end
    end
    if (hdr_valid_o) begin
      if (hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
      else begin
        he = hdr_q.pop_front();
        check("hdr_type", {30'h0, hdr_type_o}, {30'h0, he[33:32]});
        check("hdr_txfn", {16'h0, hdr_txfn_o}, {16'h0, he[31:16]});
        check("hdr_len", {16'h0, hdr_len_o}, {16'h0, he[15:0]});
      end
    end
    if (frame_ok_o || frame_err_o) begin
      if (st_q.size() == 0) check("status_unexpected", 1, 0);
      else begin
        se = st_q.pop_front();
        check("frame_ok", {31'h0, frame_ok_o}, {31'h0, se.ok});
        check("frame_err", {31'h0, frame_err_o}, {31'h0, !se.ok});
        if (!se.ok) check("err_code", {30'h0, err_code_o}, {30'h0, se.code});
        check("seq_gap", {31'h0, seq_gap_o}, {31'h0, se.gap});
        check("frame_count", {16'h0, frame_count_o}, {16'h0, se.cnt});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    while (gap > 0 && $urandom_range(99) < gap) begin
      in_valid_i = 1'b0;
      tick();
    end
    in_valid_i = 1'b1;
    in_data_i  = b;
    tick();
    in_valid_i = 1'b0;
  endtask

  // rnd=0 fills payload with 'fill'; abort_at>=0 stops after that many payload bytes.
  task automatic send_frame(input logic [7:0] typ, input logic [15:0] txfn, input logic [15:0] len,
                            input logic [7:0] fill, input bit rnd, input bit corrupt,
                            input int gap, input int abort_at);
    logic [7:0]  hdr[5];
    logic [7:0]  pay[$];
    logic [15:0] crc;
    logic [1:0]  code;
    status_t     s;
    hdr = '{typ, txfn[15:8], txfn[7:0], len[15:8], len[7:0]};
    code = (typ[7:2] != 0) ? 2'd1 : ((len == 0 || len > 16'd4096) ? 2'd2 : 2'd0);
    crc = 16'hFFFF;
    for (int i = 0; i < 5; i++) crc = crc_bits(crc, hdr[i]);
    if (code == 2'd0) begin
      for (int i = 0; i < int'(len); i++) begin
        pay.push_back(rnd ? 8'($urandom) : fill);
        crc = crc_bits(crc, pay[i]);
      end
    end
    send_byte(8'h1A, gap);
    send_byte(8'hCF, gap);
    for (int i = 0; i < 4; i++) send_byte(hdr[i], gap);
    if (code != 2'd0) begin
      s = '{ok: 1'b0, code: code, gap: 1'b0, cnt: good_cnt};
      st_q.push_back(s);
      send_byte(hdr[4], gap);
      return;
    end
    hdr_q.push_back({typ[1:0], txfn, len});
    send_byte(hdr[4], gap);
    for (int i = 0; i < int'(len); i++) begin
      if (i == abort_at) return;
      pay_q.push_back({(i == 0), (i == int'(len) - 1), pay[i]});
      send_byte(pay[i], gap);
    end
    if (corrupt) crc[0] = ~crc[0];
    send_byte(crc[15:8], gap);
    if (corrupt) s = '{ok: 1'b0, code: 2'd3, gap: 1'b0, cnt: good_cnt};
    else begin
      s.ok  = 1'b1;
      s.code = 2'd0;
      s.gap = have_prev && (txfn != prev_txfn + 16'd1);
      prev_txfn = txfn;
      have_prev = 1'b1;
      good_cnt  = good_cnt + 16'd1;
      s.cnt = good_cnt;
    end
    st_q.push_back(s);
    send_byte(crc[7:0], gap);
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check({tag, "_pay_left"}, pay_q.size(), 0);
    check({tag, "_hdr_left"}, hdr_q.size(), 0);
    check({tag, "_st_left"}, st_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulses"}, {26'h0, out_valid_o, out_sof_o, out_eof_o, hdr_valid_o,
                             frame_ok_o, frame_err_o}, 0);
    check({tag, "_data"}, {6'h0, out_data_o, err_code_o, seq_gap_o, hdr_type_o,
                           frame_count_o}, 0);
    check({tag, "_hdr"}, {hdr_txfn_o, hdr_len_o}, 0);
  endtask

  initial begin
    #2;
    check_zero("reset");
    repeat (2) tick();
    rst_ni = 1'b1;
    tick();

    // Basic frame followed gaplessly by 0x1235, then a skipped TXFN.
    send_frame(8'h01, 16'h1234, 16'd20, 8'hAA, 1'b0, 1'b0, 0, -1);
    send_frame(8'h02, 16'h1235, 16'd7, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h03, 16'h1237, 16'd1, 8'h1A, 1'b0, 1'b0, 0, -1);
    drain("b2b");
    check("count3", {16'h0, frame_count_o}, 32'd3);

    // TXFN wrap.
    send_frame(8'h00, 16'hFFFF, 16'd3, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h00, 16'h0000, 16'd3, 8'h00, 1'b1, 1'b0, 0, -1);
    drain("wrap");

    // Corrupted CRC then the next in sequence.
    send_frame(8'h01, 16'h0001, 16'd5, 8'h00, 1'b1, 1'b1, 0, -1);
    send_frame(8'h01, 16'h0001, 16'd5, 8'h00, 1'b1, 1'b0, 0, -1);
    drain("crc");

    // Header errors, each followed by a good frame.
    send_frame(8'h05, 16'h0002, 16'd4, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h01, 16'h0002, 16'd4, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h01, 16'h0003, 16'd0, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h01, 16'h0003, 16'd2, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h01, 16'h0004, 16'd4097, 8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'h01, 16'h0004, 16'd4096, 8'h00, 1'b1, 1'b0, 0, -1);
    drain("hdr_err");

    // Junk then a doubled sync high byte, random idle gaps.
    send_byte(8'h00, 30);
    send_byte(8'h1A, 30);
    send_frame(8'h02, 16'h0005, 16'd12, 8'h00, 1'b1, 1'b0, 30, -1);
    drain("robust");

    // Reset mid-payload.
    send_frame(8'h01, 16'h0006, 16'd20, 8'h00, 1'b1, 1'b0, 0, 8);
    rst_ni = 1'b0;
    pay_q.delete();
    hdr_q.delete();
    st_q.delete();
    have_prev = 1'b0;
    good_cnt  = 16'h0;
    #1;
    check_zero("midrst");
    repeat (3) tick();
    check_zero("midrst_hold");
    rst_ni = 1'b1;
    tick();
    send_frame(8'h01, 16'h4321, 16'd6, 8'h00, 1'b1, 1'b0, 0, -1);
    drain("post_rst");
    check("post_rst_count", {16'h0, frame_count_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
